// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types, field positions and helpers for the PPI Port C BSR queue
package ppi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((1 << n) < value) begin
            n = n + 1;
        end
        return n;
    endfunction

    // Control-word field positions.
    function automatic int mode_pos(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int pulse_pos(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int sel_msb(input int sel_w);
        return sel_w;
    endfunction

    function automatic int sel_lsb();
        return 1;
    endfunction

    function automatic int value_pos();
        return 0;
    endfunction

endpackage

// File: rtl/ppi_cmd_fifo.sv
// rtl/ppi_cmd_fifo.sv - synchronous command FIFO with full/empty status and a one-cycle drop flag
// Ports: clk, reset (sync, active-high), wr/data_in (write side), pop/data_out (read side, head is
// always visible on data_out), full, empty, drop (write discarded because the FIFO was full).
module ppi_cmd_fifo
    import ppi_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pull;

    // A full FIFO refuses the write even when a pop frees a slot on the same edge.
    assign push = wr && !full;
    assign pull = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pull) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pull);
            drop  <= wr && full;
        end
    end

    assign data_out = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/ppi_bsr_queue.sv
// rtl/ppi_bsr_queue.sv - queued Port C bit set/reset executor with timed pulse mode
// Ports: clk, reset (sync, active-high), PortD/wr (control word write), ENABLE (execution gate),
// PortC (registered Port C bits), full/empty (command FIFO status), busy (pulse in progress),
// drop (one-cycle flag for a write lost to a full FIFO).
module ppi_bsr_queue
    import ppi_pkg::*;
#(
    parameter int PORT_W       = 8,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] PortD,
    input  logic              wr,
    input  logic              ENABLE,
    output logic [PORT_W-1:0] PortC,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              drop
);

    localparam int SEL_W = clog2(PORT_W);
    // Only mode, pulse, select and value are queued; ignored bits never enter the FIFO,
    // so an X on them cannot reach PortC.
    localparam int CMD_W = SEL_W + 3;
    localparam int CNT_W = clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    logic [CMD_W-1:0] cmd_in;
    logic [CMD_W-1:0] head;
    logic             pop;
    logic             is_mode;
    logic             is_pulse;
    logic [SEL_W-1:0] sel;
    logic             value;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pulse_sel;
    logic             saved;

    assign cmd_in = {PortD[mode_pos(DATA_W)], PortD[pulse_pos(DATA_W)],
                     PortD[sel_msb(SEL_W):sel_lsb()], PortD[value_pos()]};

    generate
        if (DATA_W > SEL_W + 3) begin : g_ignored
            logic unused_ignored;
            assign unused_ignored = ^PortD[DATA_W-3:SEL_W+1];
        end
    endgenerate

    ppi_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .data_in  (cmd_in),
        .pop      (pop),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .drop     (drop)
    );

    assign is_mode  = head[CMD_W-1];
    assign is_pulse = head[CMD_W-2];
    assign sel      = head[SEL_W:1];
    assign value    = head[0];

    assign pop  = (state == IDLE) && !empty && ENABLE;
    assign busy = (state == PULSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop && !is_mode && is_pulse) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Port C datapath and pulse timer. A mode word wins over its pulse flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            PortC     <= '0;
            cnt       <= '0;
            pulse_sel <= '0;
            saved     <= 1'b0;
        end else if (state == PULSE) begin
            if (cnt == '0) begin
                PortC[pulse_sel] <= saved;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (pop) begin
            if (is_mode) begin
                PortC <= '0;
            end else begin
                PortC[sel] <= value;
                if (is_pulse) begin
                    saved     <= PortC[sel];
                    pulse_sel <= sel;
                    cnt       <= CNT_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi_bsr_queue.sv
// tb/tb_ppi_bsr_queue.sv - self-checking bench for ppi_bsr_queue
module tb_ppi_bsr_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] PortD;
    logic       wr;
    logic       ENABLE;
    logic [7:0] PortC;
    logic       full;
    logic       empty;
    logic       busy;
    logic       drop;

    int checks = 0;
    int errors = 0;

    ppi_bsr_queue #(
        .PORT_W       (8),
        .DATA_W       (8),
        .DEPTH        (4),
        .PULSE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .PortD  (PortD),
        .wr     (wr),
        .ENABLE (ENABLE),
        .PortC  (PortC),
        .full   (full),
        .empty  (empty),
        .busy   (busy),
        .drop   (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       en;
        logic [7:0] pc;
        logic       e;
        logic       f;
        logic       b;
        logic       dr;
    } vec_t;

    vec_t vt[$];

    // Reference model: queue of pending words, Port C image, remaining pulse cycles.
    logic [7:0] m_port;
    logic [7:0] m_q[$];
    int         m_left;
    int         m_sel;
    logic       m_saved;
    logic       m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void addv(input logic w, input logic [7:0] d, input logic en,
                                 input logic [7:0] pc, input logic e, input logic f,
                                 input logic b, input logic dr);
        vec_t v;
        v.w = w; v.d = d; v.en = en; v.pc = pc; v.e = e; v.f = f; v.b = b; v.dr = dr;
        vt.push_back(v);
    endfunction

    function automatic void model_reset();
        m_port  = 8'h00;
        m_q     = {};
        m_left  = 0;
        m_sel   = 0;
        m_saved = 1'b0;
        m_drop  = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic [7:0] d, input logic en);
        int         n0;
        logic [7:0] h;
        n0     = m_q.size();
        m_drop = w && (n0 == 4);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_port[m_sel] = m_saved;
        end else if (en && n0 > 0) begin
            h = m_q.pop_front();
            if (h[7]) begin
                m_port = 8'h00;
            end else if (h[6]) begin
                m_sel         = int'(h[3:1]);
                m_saved       = m_port[m_sel];
                m_port[m_sel] = h[0];
                m_left        = 4;
            end else begin
                m_port[h[3:1]] = h[0];
            end
        end
        if (w && n0 < 4) m_q.push_back(d);
    endfunction

    task automatic cycle(input logic w, input logic [7:0] d, input logic en);
        wr     = w;
        PortD  = d;
        ENABLE = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr     = 1'b0;
        PortD  = 8'h00;
        ENABLE = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] xw;
        logic       w;
        logic [7:0] d;
        logic       en;

        reset  = 1'b1;
        wr     = 1'b0;
        PortD  = 8'h00;
        ENABLE = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_portc", PortC, 8'h00);
        chk("reset_full", full, 1'b0);
        chk("reset_empty", empty, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_drop", drop, 1'b0);
        reset = 1'b0;

        // latency, queued execution, FIFO full/drop, mode word and ignored bits
        addv(1, 8'h09, 1, 8'h00, 0, 0, 0, 0);
        addv(1, 8'h08, 1, 8'h10, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        addv(1, 8'h03, 0, 8'h00, 0, 0, 0, 0);
        addv(1, 8'h05, 0, 8'h00, 0, 0, 0, 0);
        addv(1, 8'h07, 0, 8'h00, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h02, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h06, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h0E, 1, 0, 0, 0);
        addv(1, 8'h09, 0, 8'h0E, 0, 0, 0, 0);
        addv(1, 8'h0B, 0, 8'h0E, 0, 0, 0, 0);
        addv(1, 8'h0D, 0, 8'h0E, 0, 0, 0, 0);
        addv(1, 8'h0F, 0, 8'h0E, 0, 1, 0, 0);
        addv(1, 8'h01, 0, 8'h0E, 0, 1, 0, 1);
        addv(0, 8'h00, 1, 8'h1E, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h3E, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h7E, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'hFE, 1, 0, 0, 0);
        addv(0, 8'h00, 1, 8'hFE, 1, 0, 0, 0);
        addv(1, 8'h01, 1, 8'hFE, 0, 0, 0, 0);
        addv(1, 8'h80, 1, 8'hFF, 0, 0, 0, 0);
        addv(1, 8'h35, 1, 8'h00, 0, 0, 0, 0);
        addv(0, 8'h00, 1, 8'h04, 1, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].w, vt[i].d, vt[i].en);
            chk($sformatf("vec%0d_portc", i), PortC, vt[i].pc);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].e);
            chk($sformatf("vec%0d_full", i), full, vt[i].f);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].b);
            chk($sformatf("vec%0d_drop", i), drop, vt[i].dr);
        end

        // X on ignored bits must not reach PortC
        xw = 8'b00xx_0101;
        cycle(1, xw, 1);
        chk("xword_queued", PortC, 8'h04);
        cycle(0, 8'h00, 1);
        chk("xword_portc", PortC, 8'h04);
        chk("xword_known", 32'($isunknown(PortC)), 32'd0);

        // pulse of bit 7 followed by a plain set of bit 0
        do_reset();
        cycle(1, 8'h4F, 1);
        chk("pulse_pre", PortC, 8'h00);
        cycle(1, 8'h01, 1);
        chk("pulse_c1_portc", PortC, 8'h80);
        chk("pulse_c1_busy", busy, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            cycle(0, 8'h00, 1);
            chk($sformatf("pulse_c%0d_portc", i), PortC, 8'h80);
            chk($sformatf("pulse_c%0d_busy", i), busy, 1'b1);
        end
        cycle(0, 8'h00, 1);
        chk("pulse_restore_portc", PortC, 8'h00);
        chk("pulse_restore_busy", busy, 1'b0);
        cycle(0, 8'h00, 1);
        chk("pulse_next_portc", PortC, 8'h01);
        chk("pulse_next_empty", empty, 1'b1);

        // reset two cycles into a pulse of bit 3
        do_reset();
        cycle(1, 8'h47, 1);
        cycle(1, 8'h01, 1);
        chk("rstp_start", PortC, 8'h08);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstp_portc", PortC, 8'h00);
        chk("rstp_busy", busy, 1'b0);
        chk("rstp_empty", empty, 1'b1);
        chk("rstp_full", full, 1'b0);
        reset = 1'b0;
        model_reset();
        cycle(1, 8'h03, 1);
        chk("rstp_after_empty", empty, 1'b0);
        cycle(0, 8'h00, 1);
        chk("rstp_after_portc", PortC, 8'h02);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            w  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
            if ($urandom_range(0, 3) != 0) d[6] = 1'b0;
            en = ($urandom_range(0, 3) != 0);
            cycle(w, d, en);
            model_step(w, d, en);
            chk($sformatf("rnd%0d_portc", i), PortC, m_port);
            chk($sformatf("rnd%0d_empty", i), empty, m_q.size() == 0);
            chk($sformatf("rnd%0d_full", i), full, m_q.size() == 4);
            chk($sformatf("rnd%0d_busy", i), busy, m_left > 0);
            chk($sformatf("rnd%0d_drop", i), drop, m_drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
